// File: rtl/srm_pkg.sv
// Shared types and helpers for the SRM/RNL neuron: synapse FSM state encoding
// plus saturating add/subtract used by the weight update and membrane potential.
// No ports; imported by rnl_synapse and srm_rnl_neuron.
package srm_pkg;

  typedef enum logic [1:0] {
    SYN_IDLE = 2'd0,
    SYN_RAMP = 2'd1,
    SYN_DONE = 2'd2
  } syn_state_e;

  // a + b clamped to max; operands are zero-extended by the caller.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

  // a - b floored at zero.
  function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                          input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/srm_rnl_neuron_if.sv
// Bundle of wave-control, synapse and result signals of one neuron.
// master: drives grst, input_spikes, w_init, w_load, inc, dec, threshold.
// slave:  the neuron; drives output_spike, weights, spike_time, fired.
interface srm_rnl_neuron_if #(
  parameter int INP  = 4,
  parameter int WRES = 3,
  parameter int PRES = 6,
  parameter int TRES = 5
);
  logic                   grst;
  logic [INP-1:0]         input_spikes;
  logic [INP*WRES-1:0]    w_init;
  logic                   w_load;
  logic [INP-1:0]         inc;
  logic [INP-1:0]         dec;
  logic [PRES-1:0]        threshold;
  logic                   output_spike;
  logic [INP*WRES-1:0]    weights;
  logic [TRES-1:0]        spike_time;
  logic                   fired;

  modport master (
    output grst, input_spikes, w_init, w_load, inc, dec, threshold,
    input  output_spike, weights, spike_time, fired
  );

  modport slave (
    input  grst, input_spikes, w_init, w_load, inc, dec, threshold,
    output output_spike, weights, spike_time, fired
  );
endinterface

// File: rtl/rnl_synapse.sv
// One race-logic synapse: weight register with STDP/load update at grst, input
// edge detect, IDLE/RAMP/DONE FSM and ramp down-counter.
// Ports: clk, rst, grst_i, spike_i, w_load_i, w_init_i, inc_i, dec_i -> weight_o, resp_o.
module rnl_synapse
  import srm_pkg::*;
#(
  parameter int WRES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            grst_i,
  input  logic            spike_i,
  input  logic            w_load_i,
  input  logic [WRES-1:0] w_init_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [WRES-1:0] weight_o,
  output logic            resp_o
);

  localparam logic [31:0] WMAX = 32'((1 << WRES) - 1);

  syn_state_e      state_q, state_d;
  logic [WRES-1:0] cnt_q, cnt_d;
  logic [WRES-1:0] w_q, w_d;
  logic            spike_q;
  logic            edge_seen;

  assign edge_seen = spike_i & ~spike_q;

  // Weight update happens only at the wave boundary; load has priority over STDP.
  always_comb begin
    w_d = w_q;
    if (grst_i) begin
      if (w_load_i) begin
        w_d = w_init_i;
      end else if (inc_i && !dec_i) begin
        w_d = WRES'(sat_add(32'(w_q), 32'd1, WMAX));
      end else if (dec_i && !inc_i) begin
        w_d = WRES'(sat_sub(32'(w_q), 32'd1));
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYN_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and ramp counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (grst_i) begin
      // An edge arriving with grst belongs to the new wave, so it ramps with
      // the weight that wave will use.
      state_d = SYN_IDLE;
      cnt_d   = '0;
      if (edge_seen) begin
        cnt_d   = w_d;
        state_d = (w_d == '0) ? SYN_DONE : SYN_RAMP;
      end
    end else begin
      case (state_q)
        SYN_IDLE: begin
          if (edge_seen) begin
            cnt_d   = w_q;
            state_d = (w_q == '0) ? SYN_DONE : SYN_RAMP;
          end
        end
        SYN_RAMP: begin
          cnt_d = cnt_q - WRES'(1);
          if (cnt_q == WRES'(1)) state_d = SYN_DONE;
        end
        SYN_DONE: state_d = SYN_DONE;
        default:  state_d = SYN_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    resp_o   = (state_q == SYN_RAMP);
    weight_o = w_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      w_q     <= '0;
      spike_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      spike_q <= spike_i;
    end
  end

endmodule

// File: rtl/srm_rnl_neuron.sv
// SRM neuron with race-logic synapses: INP synapses feed a popcount into a
// saturating (optionally leaky) membrane potential that fires one pulse per wave.
// Ports: clk, rst, bus (srm_rnl_neuron_if.slave: wave control in, spike/weights/time out).
module srm_rnl_neuron
  import srm_pkg::*;
#(
  parameter int INP     = 4,
  parameter int WRES    = 3,
  parameter int PRES    = 6,
  parameter int TRES    = 5,
  parameter int LEAK_EN = 0
) (
  input  logic           clk,
  input  logic           rst,
  srm_rnl_neuron_if.slave bus
);

  localparam int              WMAX      = (1 << WRES) - 1;
  localparam int              CW        = $clog2(INP + 1);
  localparam int              PW        = WRES + 1;
  localparam logic [PW-1:0]   PULSE_LEN = PW'(WMAX + 1);
  localparam logic [PRES-1:0] POT_MAX   = '1;

  logic [INP-1:0]      resp;
  logic [INP*WRES-1:0] weights;
  logic [CW-1:0]       resp_cnt;

  logic [PRES-1:0] pot_q, pot_d;
  logic            fired_q, fired_d;
  logic [TRES-1:0] wave_q, wave_d;
  logic [TRES-1:0] spike_time_q, spike_time_d;
  logic [PW-1:0]   pulse_q, pulse_d;
  logic            fire;

  for (genvar i = 0; i < INP; i++) begin : g_syn
    rnl_synapse #(.WRES(WRES)) u_syn (
      .clk      (clk),
      .rst      (rst),
      .grst_i   (bus.grst),
      .spike_i  (bus.input_spikes[i]),
      .w_load_i (bus.w_load),
      .w_init_i (bus.w_init[i*WRES +: WRES]),
      .inc_i    (bus.inc[i]),
      .dec_i    (bus.dec[i]),
      .weight_o (weights[i*WRES +: WRES]),
      .resp_o   (resp[i])
    );
  end

  always_comb begin
    resp_cnt = '0;
    for (int i = 0; i < INP; i++) resp_cnt = resp_cnt + CW'(resp[i]);
  end

  // Threshold is read live, so a mid-wave change applies on the next compare.
  assign fire = (bus.threshold != '0) && !fired_q && (pot_q >= bus.threshold);

  always_comb begin
    if ((LEAK_EN != 0) && (resp_cnt == '0)) begin
      pot_d = PRES'(sat_sub(32'(pot_q), 32'd1));
    end else begin
      pot_d = PRES'(sat_add(32'(pot_q), 32'(resp_cnt), 32'(POT_MAX)));
    end

    wave_d       = (wave_q == '1) ? wave_q : wave_q + TRES'(1);
    fired_d      = fired_q;
    spike_time_d = spike_time_q;
    pulse_d      = (pulse_q != '0) ? pulse_q - PW'(1) : pulse_q;
    if (fire) begin
      fired_d      = 1'b1;
      spike_time_d = wave_q;
      pulse_d      = PULSE_LEN;
    end
  end

  // grst clears the wave state exactly like rst, truncating any pulse in flight.
  always_ff @(posedge clk) begin
    if (rst || bus.grst) begin
      pot_q        <= '0;
      fired_q      <= 1'b0;
      wave_q       <= '0;
      spike_time_q <= '1;
      pulse_q      <= '0;
    end else begin
      pot_q        <= pot_d;
      fired_q      <= fired_d;
      wave_q       <= wave_d;
      spike_time_q <= spike_time_d;
      pulse_q      <= pulse_d;
    end
  end

  assign bus.output_spike = (pulse_q != '0);
  assign bus.weights      = weights;
  assign bus.spike_time   = spike_time_q;
  assign bus.fired        = fired_q;

endmodule
